// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator with a one-pixel-ahead request / colour-return pipeline.
// Optional build macro VGA_TEST_PATTERN_EN adds pat_sel and an 8-bar colour test pattern.
module vga_timing_gen #(
    parameter int   H_SYNC   = 152,
    parameter int   H_BP     = 232,
    parameter int   H_ACTIVE = 1440,
    parameter int   H_FP     = 80,
    parameter int   V_SYNC   = 3,
    parameter int   V_BP     = 28,
    parameter int   V_ACTIVE = 900,
    parameter int   V_FP     = 1,
    parameter logic H_POL    = 1'b0,
    parameter logic V_POL    = 1'b1,
    parameter int   CW       = 4,
    parameter int   XW       = 11,
    parameter int   YW       = 10
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pix_ce,
`ifdef VGA_TEST_PATTERN_EN
    input  logic            pat_sel,
`endif
    output logic [XW-1:0]   pix_x,
    output logic [YW-1:0]   pix_y,
    output logic            pix_req,
    input  logic [3*CW-1:0] rgb_in,
    output logic [CW-1:0]   pix_r,
    output logic [CW-1:0]   pix_g,
    output logic [CW-1:0]   pix_b,
    output logic            hsync,
    output logic            vsync,
    output logic            de,
    output logic            frame_start,
    output logic            line_start
);

    localparam int H_TOT   = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int V_TOT   = V_SYNC + V_BP + V_ACTIVE + V_FP;
    localparam int H_START = H_SYNC + H_BP;
    localparam int V_START = V_SYNC + V_BP;

    localparam logic [XW-1:0] H_LAST_C  = XW'(H_TOT - 1);
    localparam logic [YW-1:0] V_LAST_C  = YW'(V_TOT - 1);
    localparam logic [XW-1:0] H_START_C = XW'(H_START);
    localparam logic [YW-1:0] V_START_C = YW'(V_START);
    localparam logic [XW-1:0] H_END_C   = XW'(H_START + H_ACTIVE - 1);
    localparam logic [YW-1:0] V_END_C   = YW'(V_START + V_ACTIVE - 1);
    localparam logic [XW-1:0] H_SEND_C  = XW'(H_SYNC - 1);
    localparam logic [YW-1:0] V_SEND_C  = YW'(V_SYNC - 1);

    // Counters must be able to reach the last position of a line and of a frame.
    if (H_TOT - 1 >= (1 << XW)) begin : g_xw_check
        $error("vga_timing_gen: XW too narrow for H_TOT-1");
    end
    if (V_TOT - 1 >= (1 << YW)) begin : g_yw_check
        $error("vga_timing_gen: YW too narrow for V_TOT-1");
    end

    logic [XW-1:0]   hcount;
    logic [YW-1:0]   vcount;
    logic            h_act;
    logic            v_act;
    logic            active;
    logic            s0_hs;
    logic            s0_vs;
    logic            s0_frame;
    logic            s0_line;
    logic [3*CW-1:0] colour_src;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hcount <= '0;
            vcount <= '0;
        end else if (pix_ce) begin
            if (hcount == H_LAST_C) begin
                hcount <= '0;
                vcount <= (vcount == V_LAST_C) ? '0 : vcount + 1'b1;
            end else begin
                hcount <= hcount + 1'b1;
            end
        end
    end

    always_comb begin
        h_act  = (hcount >= H_START_C) && (hcount <= H_END_C);
        v_act  = (vcount >= V_START_C) && (vcount <= V_END_C);
        active = h_act && v_act;
    end

    // Stage 0: request coordinates plus the sync/strobe flags that ride along to stage 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pix_req  <= 1'b0;
            pix_x    <= '0;
            pix_y    <= '0;
            s0_hs    <= 1'b0;
            s0_vs    <= 1'b0;
            s0_frame <= 1'b0;
            s0_line  <= 1'b0;
        end else if (pix_ce) begin
            pix_req  <= active;
            pix_x    <= active ? hcount - H_START_C : '0;
            pix_y    <= active ? vcount - V_START_C : '0;
            s0_hs    <= (hcount <= H_SEND_C);
            s0_vs    <= (vcount <= V_SEND_C);
            s0_frame <= active && (hcount == H_START_C) && (vcount == V_START_C);
            s0_line  <= active && (hcount == H_START_C);
        end
    end

`ifdef VGA_TEST_PATTERN_EN
    logic [XW+2:0] bar_full;
    logic [2:0]    bar;

    always_comb begin
        bar_full = {pix_x, 3'b000} / (XW+3)'(H_ACTIVE);
        bar      = bar_full[2:0];
        if (pat_sel) begin
            colour_src = {{CW{bar[2]}}, {CW{bar[1]}}, {CW{bar[0]}}};
        end else begin
            colour_src = rgb_in;
        end
    end
`else
    always_comb begin
        colour_src = rgb_in;
    end
`endif

    // Stage 1: display outputs, aligned with the colour returned for the stage-0 request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hsync       <= ~H_POL;
            vsync       <= ~V_POL;
            de          <= 1'b0;
            frame_start <= 1'b0;
            line_start  <= 1'b0;
            pix_r       <= '0;
            pix_g       <= '0;
            pix_b       <= '0;
        end else if (pix_ce) begin
            hsync       <= s0_hs ? H_POL : ~H_POL;
            vsync       <= s0_vs ? V_POL : ~V_POL;
            de          <= pix_req;
            frame_start <= s0_frame;
            line_start  <= s0_line;
            if (pix_req) begin
                {pix_r, pix_g, pix_b} <= colour_src;
            end else begin
                {pix_r, pix_g, pix_b} <= '0;
            end
        end
    end

endmodule
